sdram_arbiter: RTL and testbench

- Central scheduler for the single-port SDRAM behind sdram_top. It holds off all traffic until power-up initialisation completes.
- It generates periodic auto-refresh requests and latches user write/read triggers.
- It grants the SDRAM command/address bus to exactly one sub-sequencer (init, auto-refresh, write, read) at a time, and muxes the granted sequencer's command and address onto the SDRAM pins.

---
 rtl/sdram_arbiter_if.sv | 37 +++
 rtl/sdram_arbiter.sv | 95 +++++++++
 tb/tb_sdram_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - sequencer-side handshake and command bus for sdram_arbiter
interface sdram_arbiter_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        wr_trig;
    logic        rd_trig;
    logic        aref_end;
    logic        wr_end;
    logic        rd_end;
    logic [3:0]  aref_cmd;
    logic [3:0]  wr_cmd;
    logic [3:0]  rd_cmd;
    logic [11:0] aref_addr;
    logic [11:0] wr_addr;
    logic [11:0] rd_addr;
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic        ref_overrun;

    modport slave (
        input  init_end, init_cmd, init_addr, wr_trig, rd_trig,
        input  aref_end, wr_end, rd_end,
        input  aref_cmd, wr_cmd, rd_cmd, aref_addr, wr_addr, rd_addr,
        output aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, ref_overrun
    );

    modport master (
        output init_end, init_cmd, init_addr, wr_trig, rd_trig,
        output aref_end, wr_end, rd_end,
        output aref_cmd, wr_cmd, rd_cmd, aref_addr, wr_addr, rd_addr,
        input  aref_en, wr_en, rd_en, sdram_cmd, sdram_addr, ref_overrun
    );
endinterface

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command-bus scheduler: init gate, refresh timer, single grant
module sdram_arbiter #(
    parameter int         REF_CYCLES = 750,
    parameter logic [3:0] NOP_CMD    = 4'b0111
) (
    input  logic             S_CLK,
    input  logic             S_RST,
    sdram_arbiter_if.slave   bus
);
    localparam int CW = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

    state_t        r_state;
    logic [CW-1:0] r_ref_cnt;
    logic          r_ref_pend;
    logic          r_wr_pend;
    logic          r_rd_pend;
    logic          r_ref_overrun;

    logic w_wrap;
    logic w_grant_ref;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_wrap      = (r_state != INIT) && (r_ref_cnt == CW'(REF_CYCLES - 1));
    assign w_grant_ref = (r_state == ARBIT) && r_ref_pend;
    assign w_grant_wr  = (r_state == ARBIT) && !r_ref_pend && r_wr_pend;
    assign w_grant_rd  = (r_state == ARBIT) && !r_ref_pend && !r_wr_pend && r_rd_pend;

    always_ff @(posedge S_CLK) begin
        if (S_RST) begin
            r_state       <= INIT;
            r_ref_cnt     <= '0;
            r_ref_pend    <= 1'b0;
            r_wr_pend     <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_ref_overrun <= 1'b0;
        end else begin
            case (r_state)
                INIT:    if (bus.init_end) r_state <= ARBIT;
                ARBIT: begin
                    if (w_grant_ref)     r_state <= AREF;
                    else if (w_grant_wr) r_state <= WRITE;
                    else if (w_grant_rd) r_state <= READ;
                end
                AREF:    if (bus.aref_end) r_state <= ARBIT;
                WRITE:   if (bus.wr_end)   r_state <= ARBIT;
                READ:    if (bus.rd_end)   r_state <= ARBIT;
                default: r_state <= INIT;
            endcase

            if (r_state == INIT || w_wrap) r_ref_cnt <= '0;
            else                           r_ref_cnt <= r_ref_cnt + CW'(1);

            // A new request always outranks the clear of the flag it targets
            r_ref_pend    <= w_wrap      | (r_ref_pend & ~w_grant_ref);
            r_wr_pend     <= bus.wr_trig | (r_wr_pend  & ~w_grant_wr);
            r_rd_pend     <= bus.rd_trig | (r_rd_pend  & ~w_grant_rd);
            r_ref_overrun <= r_ref_overrun | (w_wrap & r_ref_pend);
        end
    end

    assign bus.aref_en     = (r_state == AREF);
    assign bus.wr_en       = (r_state == WRITE);
    assign bus.rd_en       = (r_state == READ);
    assign bus.ref_overrun = r_ref_overrun;

    always_comb begin
        bus.sdram_cmd  = NOP_CMD;
        bus.sdram_addr = 12'd0;
        case (r_state)
            INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            AREF: begin
                bus.sdram_cmd  = bus.aref_cmd;
                bus.sdram_addr = bus.aref_addr;
            end
            WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
            end
            READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
            end
            default: begin
                bus.sdram_cmd  = NOP_CMD;
                bus.sdram_addr = 12'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed bench for sdram_arbiter with an 8-cycle refresh period
module tb_sdram_arbiter;
    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    sdram_arbiter_if u_bus ();

    sdram_arbiter #(.REF_CYCLES(8)) u_dut (
        .S_CLK (clk),
        .S_RST (rst),
        .bus   (u_bus)
    );

    localparam logic [3:0]  INIT_C = 4'b0010, AREF_C = 4'b0001, WR_C = 4'b0100, RD_C = 4'b0101;
    localparam logic [11:0] INIT_A = 12'h400, AREF_A = 12'h0A5, WR_A = 12'h123, RD_A = 12'h321;
    localparam logic [2:0]  EN_NONE = 3'b000, EN_REF = 3'b100, EN_WR = 3'b010, EN_RD = 3'b001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] en3();
        return {13'd0, u_bus.aref_en, u_bus.wr_en, u_bus.rd_en};
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        u_bus.init_end = 0; u_bus.wr_trig = 0; u_bus.rd_trig = 0;
        u_bus.aref_end = 0; u_bus.wr_end = 0; u_bus.rd_end = 0;
        u_bus.init_cmd = INIT_C; u_bus.init_addr = INIT_A;
        u_bus.aref_cmd = AREF_C; u_bus.aref_addr = AREF_A;
        u_bus.wr_cmd   = WR_C;   u_bus.wr_addr   = WR_A;
        u_bus.rd_cmd   = RD_C;   u_bus.rd_addr   = RD_A;

        tick();
        check("rst_en",      en3(), {13'd0, EN_NONE});
        check("rst_cmd",     {12'd0, u_bus.sdram_cmd}, {12'd0, INIT_C});
        check("rst_addr",    {4'd0, u_bus.sdram_addr}, {4'd0, INIT_A});
        check("rst_overrun", {15'd0, u_bus.ref_overrun}, 16'd0);
        rst = 1'b0;

        tick(10);
        check("init_hold_cmd", {12'd0, u_bus.sdram_cmd}, {12'd0, INIT_C});
        check("init_hold_en",  en3(), {13'd0, EN_NONE});

        // E0: leave INIT; refresh counter starts from here
        u_bus.init_end = 1; tick(); u_bus.init_end = 0;
        check("arbit_cmd",  {12'd0, u_bus.sdram_cmd}, 16'h0007);
        check("arbit_addr", {4'd0, u_bus.sdram_addr}, 16'd0);
        check("arbit_en",   en3(), {13'd0, EN_NONE});

        tick(8);                                   // E8: first wrap
        check("pre_ref_en", en3(), {13'd0, EN_NONE});
        tick();                                    // E9
        check("ref1_en",   en3(), {13'd0, EN_REF});
        check("ref1_cmd",  {12'd0, u_bus.sdram_cmd}, {12'd0, AREF_C});
        check("ref1_addr", {4'd0, u_bus.sdram_addr}, {4'd0, AREF_A});
        tick(3);
        u_bus.aref_end = 1; tick(); u_bus.aref_end = 0;   // E13
        check("ref1_done", en3(), {13'd0, EN_NONE});
        tick(3);                                   // E16
        check("ref2_wait", en3(), {13'd0, EN_NONE});
        tick();                                    // E17
        check("ref2_period", en3(), {13'd0, EN_REF});
        u_bus.aref_end = 1; tick(); u_bus.aref_end = 0;   // E18
        check("ref2_done", en3(), {13'd0, EN_NONE});

        u_bus.wr_trig = 1; u_bus.rd_trig = 1; tick();      // E19
        u_bus.wr_trig = 0; u_bus.rd_trig = 0;
        check("trig_latch", en3(), {13'd0, EN_NONE});
        tick();                                    // E20
        check("wr_first",  en3(), {13'd0, EN_WR});
        check("wr_cmd",    {12'd0, u_bus.sdram_cmd}, {12'd0, WR_C});
        check("wr_addr",   {4'd0, u_bus.sdram_addr}, {4'd0, WR_A});
        u_bus.wr_end = 1; tick(); u_bus.wr_end = 0;       // E21
        check("gap_en",  en3(), {13'd0, EN_NONE});
        check("gap_cmd", {12'd0, u_bus.sdram_cmd}, 16'h0007);
        tick();                                    // E22
        check("rd_second", en3(), {13'd0, EN_RD});
        check("rd_cmd",    {12'd0, u_bus.sdram_cmd}, {12'd0, RD_C});
        check("rd_addr",   {4'd0, u_bus.sdram_addr}, {4'd0, RD_A});
        u_bus.rd_end = 1; tick(); u_bus.rd_end = 0;       // E23
        check("rd_done", en3(), {13'd0, EN_NONE});
        tick();                                    // E24: wrap, nothing else pending
        check("served_once", en3(), {13'd0, EN_NONE});
        tick();                                    // E25
        check("ref3_en",    en3(), {13'd0, EN_REF});
        check("no_overrun", {15'd0, u_bus.ref_overrun}, 16'd0);
        u_bus.aref_end = 1; tick(); u_bus.aref_end = 0;   // E26

        u_bus.wr_trig = 1; tick(); u_bus.wr_trig = 0;     // E27
        tick();                                    // E28
        check("long_wr_en", en3(), {13'd0, EN_WR});
        u_bus.rd_trig = 1; tick(); u_bus.rd_trig = 0;     // E29
        u_bus.aref_end = 1; u_bus.rd_end = 1; tick();     // E30
        u_bus.aref_end = 0; u_bus.rd_end = 0;
        check("ignore_end", en3(), {13'd0, EN_WR});
        tick(9);                                   // E39
        check("overrun_pre", {15'd0, u_bus.ref_overrun}, 16'd0);
        tick();                                    // E40: second wrap with refresh pending
        check("overrun_set", {15'd0, u_bus.ref_overrun}, 16'd1);
        tick(7);                                   // E47
        u_bus.wr_end = 1; tick(); u_bus.wr_end = 0;       // E48
        check("long_wr_done", en3(), {13'd0, EN_NONE});
        tick();                                    // E49
        check("ref_before_rd", en3(), {13'd0, EN_REF});
        u_bus.aref_end = 1; tick(); u_bus.aref_end = 0;   // E50
        tick();                                    // E51
        check("rd_after_ref",   en3(), {13'd0, EN_RD});
        check("overrun_sticky", {15'd0, u_bus.ref_overrun}, 16'd1);

        rst = 1; u_bus.rd_trig = 1; tick(); rst = 0; u_bus.rd_trig = 0;
        check("mid_rst_en",      en3(), {13'd0, EN_NONE});
        check("mid_rst_cmd",     {12'd0, u_bus.sdram_cmd}, {12'd0, INIT_C});
        check("mid_rst_overrun", {15'd0, u_bus.ref_overrun}, 16'd0);
        u_bus.wr_trig = 1; tick(); u_bus.wr_trig = 0;
        tick(3);
        check("init_trig_hold", en3(), {13'd0, EN_NONE});
        u_bus.init_end = 1; tick(); u_bus.init_end = 0;   // I0
        check("reinit_arbit", {12'd0, u_bus.sdram_cmd}, 16'h0007);
        u_bus.wr_trig = 1; tick(); u_bus.wr_trig = 0;     // I1: trig meets its own clear
        check("init_wr_served", en3(), {13'd0, EN_WR});
        u_bus.wr_end = 1; tick(); u_bus.wr_end = 0;       // I2
        check("set_wins_gap", en3(), {13'd0, EN_NONE});
        tick();                                    // I3
        check("set_wins", en3(), {13'd0, EN_WR});
        u_bus.wr_end = 1; tick(); u_bus.wr_end = 0;       // I4
        tick();                                    // I5
        check("no_extra", en3(), {13'd0, EN_NONE});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
